// File: rtl/uart_msg_tx_pkg.sv
// uart_msg_tx_pkg: shared frame constants, framer states and bit-timing helper
package uart_msg_tx_pkg;
  localparam logic [7:0] PKT_PREFIX = 8'hDD;
  typedef enum logic [2:0] {IDLE, PREFIX, SRC, DST, LEN, PAYLOAD, CRC, FIN} state_t;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer with optional idle gap bits after the stop bit
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 416,
  parameter int GAP_BITS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [7:0] din,
  output logic       rdy,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_OPEN = CW'(CLKS_PER_BIT - 4);
  localparam logic [3:0] IDX_LAST = 4'(9 + GAP_BITS);
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic [8:0] sh;
  logic [7:0] pd, go_byte;
  logic act, pend, bit_end, last, take, go;
  always_comb begin
    bit_end = cnt == CNT_LAST;
    last = act && bit_end && idx == IDX_LAST;
    take = ld && rdy;
    go = (take && (!act || last)) || (pend && last);
    go_byte = pend ? pd : din;
  end
  // rdy reopens three clocks before the final bit ends, so the framer's registered
  // load lands on (or is held until) the exact bit boundary with no dead cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      pd <= '0;
      act <= 1'b0;
      pend <= 1'b0;
      rdy <= 1'b1;
      tx <= 1'b1;
    end else begin
      if (go) begin
        act <= 1'b1;
        cnt <= '0;
        idx <= '0;
        sh <= {1'b1, go_byte};
        tx <= 1'b0;
        pend <= 1'b0;
      end else if (last) begin
        act <= 1'b0;
        cnt <= '0;
        idx <= '0;
        tx <= 1'b1;
      end else if (act && bit_end) begin
        cnt <= '0;
        idx <= idx + 4'd1;
        tx <= sh[0];
        sh <= {1'b1, sh[8:1]};
      end else if (act) cnt <= cnt + 1'b1;
      if (take && !go) begin
        pend <= 1'b1;
        pd <= din;
      end
      if (take) rdy <= 1'b0;
      else if (act && idx == IDX_LAST && cnt == CNT_OPEN) rdy <= 1'b1;
    end
endmodule

// File: rtl/uart_msg_tx.sv
// uart_msg_tx: frames DD, src, dst, len, payload, crc onto an 8N1 UART line
module uart_msg_tx
  import uart_msg_tx_pkg::*;
#(
  parameter int CLK_HZ = 48_000_000,
  parameter int BAUD = 115200,
  parameter logic [7:0] SRC_ADDR = 8'h00,
  parameter int GAP_BITS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dst_addr,
  input  logic [7:0] len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic       busy,
  output logic       done,
  output logic       tx
);
  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  state_t state;
  logic [7:0] dst_q, len_q, crc, cnt, din;
  logic [1:0] wcnt;
  logic ld, rdy, ser_ok;
  assign ser_ok = rdy && !ld;
  uart_tx_byte #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP_BITS)) u_ser (
    .clk(clk), .rst(rst), .ld(ld), .din(din), .rdy(rdy), .tx(tx)
  );
  // FIN waits out the early-ready window so done follows the true end of the stop bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      dst_q <= '0;
      len_q <= '0;
      crc <= '0;
      cnt <= '0;
      din <= '0;
      wcnt <= '0;
      ld <= 1'b0;
      pl_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      ld <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
          dst_q <= dst_addr;
          len_q <= len;
          crc <= '0;
          cnt <= '0;
          wcnt <= '0;
          busy <= 1'b1;
          state <= PREFIX;
        end
        PREFIX: if (ser_ok) begin
          ld <= 1'b1;
          din <= PKT_PREFIX;
          state <= SRC;
        end
        SRC: if (ser_ok) begin
          ld <= 1'b1;
          din <= SRC_ADDR;
          state <= DST;
        end
        DST: if (ser_ok) begin
          ld <= 1'b1;
          din <= dst_q;
          state <= LEN;
        end
        LEN: if (ser_ok) begin
          ld <= 1'b1;
          din <= len_q;
          state <= len_q == 8'd0 ? CRC : PAYLOAD;
        end
        PAYLOAD: if (pl_valid && pl_ready) begin
          ld <= 1'b1;
          din <= pl_data;
          crc <= crc + pl_data;
          cnt <= cnt + 8'd1;
          pl_ready <= 1'b0;
          state <= cnt + 8'd1 == len_q ? CRC : PAYLOAD;
        end else pl_ready <= ser_ok;
        CRC: if (ser_ok) begin
          ld <= 1'b1;
          din <= crc;
          state <= FIN;
        end
        FIN: if (ser_ok) begin
          if (wcnt == 2'd2) begin
            done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end else wcnt <= wcnt + 2'd1;
        end
      endcase
    end
endmodule
